// File: rtl/osc_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : osc_cmd_arbiter
// Purpose  : Round-robin frame arbiter and load-strobe sequencer for the
//            oscillator command decoder byte port.
// Revision : 1.0
// ============================================================================
module osc_cmd_arbiter #(
    parameter int STROBE_HIGH    = 2,
    parameter int STROBE_GAP     = 2,
    parameter int RESYNC_STROBES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_data,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_data,
    output logic       o_req1_ready,
    output logic [7:0] o_data,
    output logic       o_data_load,
    output logic       o_grant,
    output logic       o_busy,
    output logic       o_bad_cmd
);

    localparam int CNT_MAX = (STROBE_HIGH > STROBE_GAP) ? STROBE_HIGH : STROBE_GAP;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RW      = (RESYNC_STROBES > 1) ? $clog2(RESYNC_STROBES) : 1;

    localparam logic [CW-1:0] C_HIGH_LAST   = CW'(STROBE_HIGH - 1);
    localparam logic [CW-1:0] C_GAP_LAST    = CW'(STROBE_GAP - 1);
    localparam logic [RW-1:0] C_RESYNC_LAST = RW'(RESYNC_STROBES - 1);

    typedef enum logic [2:0] {
        ST_RESYNC = 3'd0,
        ST_IDLE   = 3'd1,
        ST_FETCH  = 3'd2,
        ST_SETUP  = 3'd3,
        ST_HIGH   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        K_BYTE   = 2'd0,
        K_FLUSH  = 2'd1,
        K_RESYNC = 2'd2
    } kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [1:0]    rem_q, rem_d;
    logic          first_q, first_d;
    logic [RW-1:0] rsy_q, rsy_d;
    logic          ptr_q, ptr_d;
    logic          grant_q, grant_d;
    logic [7:0]    data_q, data_d;
    logic          load_q, load_d;
    logic          rdy0_q, rdy0_d;
    logic          rdy1_q, rdy1_d;
    logic          busy_q, busy_d;
    logic          bad_q, bad_d;

    logic          w_valid;
    logic [7:0]    w_byte;
    logic          w_fire;
    logic [1:0]    w_len;

    // Payload byte count for a command byte; zero marks an unknown command.
    function automatic logic [1:0] payload_len(input logic [7:0] cmd);
        case (cmd)
            8'h01, 8'h11:               return 2'd1;
            8'h02, 8'h12:               return 2'd3;
            8'h03, 8'h04, 8'h13, 8'h14: return 2'd2;
            default:                    return 2'd0;
        endcase
    endfunction

    assign w_valid = grant_q ? i_req1_valid : i_req0_valid;
    assign w_byte  = grant_q ? i_req1_data  : i_req0_data;
    assign w_fire  = w_valid && (grant_q ? rdy1_q : rdy0_q);
    assign w_len   = payload_len(w_byte);

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        tmr_d   = tmr_q;
        rem_d   = rem_q;
        first_d = first_q;
        rsy_d   = rsy_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        bad_d   = 1'b0;

        case (state_q)
            ST_RESYNC: begin
                data_d  = 8'h00;
                kind_d  = K_RESYNC;
                tmr_d   = C_HIGH_LAST;
                state_d = ST_HIGH;
            end
            ST_IDLE: begin
                if (i_req0_valid || i_req1_valid) begin
                    grant_d = (i_req0_valid && i_req1_valid) ? ptr_q : i_req1_valid;
                    first_d = 1'b1;
                    kind_d  = K_BYTE;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_fire) begin
                    if (first_q) begin
                        if (w_len == 2'd0) begin
                            bad_d   = 1'b1;
                            ptr_d   = ~ptr_q;
                            state_d = ST_IDLE;
                        end else begin
                            rem_d   = w_len;
                            first_d = 1'b0;
                            data_d  = w_byte;
                            state_d = ST_SETUP;
                        end
                    end else begin
                        rem_d   = rem_q - 2'd1;
                        data_d  = w_byte;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                tmr_d   = C_HIGH_LAST;
                state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (tmr_q == '0) begin
                    tmr_d   = C_GAP_LAST;
                    state_d = ST_GAP;
                end else begin
                    tmr_d = tmr_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - CW'(1);
                end else begin
                    case (kind_q)
                        K_RESYNC: begin
                            if (rsy_q != '0) begin
                                rsy_d   = rsy_q - RW'(1);
                                state_d = ST_RESYNC;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        K_FLUSH: begin
                            ptr_d   = ~ptr_q;
                            state_d = ST_IDLE;
                        end
                        default: begin
                            if (rem_q != 2'd0) begin
                                state_d = ST_FETCH;
                            end else begin
                                // Trailing 0x00 strobe commits the frame in the decoder.
                                data_d  = 8'h00;
                                kind_d  = K_FLUSH;
                                state_d = ST_SETUP;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_RESYNC;
            end
        endcase

        load_d = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
        rdy0_d = (state_d == ST_FETCH) && !grant_d;
        rdy1_d = (state_d == ST_FETCH) &&  grant_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_RESYNC;
            kind_q  <= K_RESYNC;
            tmr_q   <= '0;
            rem_q   <= 2'd0;
            first_q <= 1'b0;
            rsy_q   <= C_RESYNC_LAST;
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            data_q  <= 8'h00;
            load_q  <= 1'b0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            busy_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            rsy_q   <= rsy_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            load_q  <= load_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            busy_q  <= busy_d;
            bad_q   <= bad_d;
        end
    end

    assign o_req0_ready = rdy0_q;
    assign o_req1_ready = rdy1_q;
    assign o_data       = data_q;
    assign o_data_load  = load_q;
    assign o_grant      = grant_q;
    assign o_busy       = busy_q;
    assign o_bad_cmd    = bad_q;

endmodule
`default_nettype wire
